// File: rtl/arp_cache_responder.sv
// ARP responder with a learned IP->MAC cache and a lookup port for the IP path.
// Define ARP_GRATUITOUS_EN to emit one announce frame after reset release.
module arp_cache_responder #(
    parameter int CACHE_DEPTH = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             areset,
    input  logic [7:0]       data_rx_i,
    input  logic             data_valid_rx_i,
    input  logic             data_ack_tx_i,
    input  logic [47:0]      my_mac_i,
    input  logic [31:0]      my_ipv4_i,
    output logic             data_valid_tx_o,
    output logic [7:0]       data_tx_o,
    input  logic             lookup_req_i,
    input  logic [31:0]      lookup_ip_i,
    output logic             lookup_done_o,
    output logic             lookup_hit_o,
    output logic [47:0]      lookup_mac_o,
    output logic [CNT_W-1:0] reply_cnt_o,
    output logic [CNT_W-1:0] drop_cnt_o
);
    localparam int PW = (CACHE_DEPTH > 1) ? $clog2(CACHE_DEPTH) : 1;
    localparam logic [5:0] FLEN = 6'd42;
    localparam logic [5:0] LAST = 6'd41;

`ifdef ARP_GRATUITOUS_EN
    typedef enum logic [1:0] {IDLE, REPLY, GRAT} state_t;
`else
    typedef enum logic [1:0] {IDLE, REPLY} state_t;
`endif

    logic [5:0] rx_cnt;
    logic [7:0] rx_b [42];
    logic [47:0] f_dst;
    logic [47:0] f_sha;
    logic [31:0] f_spa;
    logic [31:0] f_tpa;
    logic [15:0] f_oper;
    logic hdr_ok;
    logic frame_end;
    logic frame_ok;
    logic learn;
    logic need_reply;

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            rx_cnt <= '0;
        end else if (!data_valid_rx_i) begin
            rx_cnt <= '0;
        end else if (rx_cnt != FLEN) begin
            rx_cnt <= rx_cnt + 6'd1;
        end
    end

    // Only the first 42 bytes are kept; padding never overwrites them.
    always_ff @(posedge clk) begin
        if (data_valid_rx_i && rx_cnt != FLEN) begin
            rx_b[rx_cnt] <= data_rx_i;
        end
    end

    assign f_dst  = {rx_b[0], rx_b[1], rx_b[2], rx_b[3], rx_b[4], rx_b[5]};
    assign f_oper = {rx_b[20], rx_b[21]};
    assign f_sha  = {rx_b[22], rx_b[23], rx_b[24],
                     rx_b[25], rx_b[26], rx_b[27]};
    assign f_spa  = {rx_b[28], rx_b[29], rx_b[30], rx_b[31]};
    assign f_tpa  = {rx_b[38], rx_b[39], rx_b[40], rx_b[41]};

    assign hdr_ok = {rx_b[12], rx_b[13]} == 16'h0806
                 && {rx_b[14], rx_b[15]} == 16'h0001
                 && {rx_b[16], rx_b[17]} == 16'h0800
                 && rx_b[18] == 8'd6
                 && rx_b[19] == 8'd4;

    assign frame_end  = !data_valid_rx_i && rx_cnt != '0;
    assign frame_ok   = frame_end && rx_cnt == FLEN && hdr_ok
                     && (f_dst == '1 || f_dst == my_mac_i)
                     && (f_oper == 16'd1 || f_oper == 16'd2);
    assign learn      = frame_ok && f_spa != '0;
    assign need_reply = frame_ok && f_oper == 16'd1 && f_tpa == my_ipv4_i;

    logic [CACHE_DEPTH-1:0] c_valid;
    logic [31:0] c_ip [CACHE_DEPTH];
    logic [47:0] c_mac [CACHE_DEPTH];
    logic [PW-1:0] ptr;
    logic [PW-1:0] l_idx;
    logic l_hit;
    logic k_hit;
    logic [47:0] k_mac;

    // Learning keeps IPs unique, so at most one entry can match.
    always_comb begin
        l_hit = 1'b0;
        l_idx = '0;
        k_hit = 1'b0;
        k_mac = '0;
        for (int i = 0; i < CACHE_DEPTH; i++) begin
            if (c_valid[i] && c_ip[i] == f_spa) begin
                l_hit = 1'b1;
                l_idx = PW'(i);
            end
            if (c_valid[i] && c_ip[i] == lookup_ip_i) begin
                k_hit = 1'b1;
                k_mac = c_mac[i];
            end
        end
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            c_valid <= '0;
            ptr     <= '0;
            for (int i = 0; i < CACHE_DEPTH; i++) begin
                c_ip[i]  <= '0;
                c_mac[i] <= '0;
            end
        end else if (learn) begin
            if (l_hit) begin
                c_mac[l_idx] <= f_sha;
            end else begin
                c_valid[ptr] <= 1'b1;
                c_ip[ptr]    <= f_spa;
                c_mac[ptr]   <= f_sha;
                ptr <= (ptr == PW'(CACHE_DEPTH - 1)) ? '0 : ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            lookup_done_o <= 1'b0;
            lookup_hit_o  <= 1'b0;
            lookup_mac_o  <= '0;
        end else begin
            lookup_done_o <= lookup_req_i;
            lookup_hit_o  <= lookup_req_i && k_hit;
            lookup_mac_o  <= (lookup_req_i && k_hit) ? k_mac : '0;
        end
    end

    state_t state;
    state_t state_nx;
    logic start_reply;
    logic tx_fire;
    logic tx_last;
    logic pend_full;
    logic [47:0] pend_sha;
    logic [31:0] pend_spa;
    logic [47:0] tx_sha;
    logic [31:0] tx_spa;
    logic [5:0] tx_idx;
    logic [335:0] tx_frame;
    logic [7:0] tx_b [42];

`ifdef ARP_GRATUITOUS_EN
    logic ann_pend;
    logic start_grat;

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            ann_pend <= 1'b1;
        end else if (start_grat) begin
            ann_pend <= 1'b0;
        end
    end
`endif

    assign data_valid_tx_o = state != IDLE;
    assign tx_fire = data_valid_tx_o && data_ack_tx_i;
    assign tx_last = tx_fire && tx_idx == LAST;

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        start_reply = 1'b0;
`ifdef ARP_GRATUITOUS_EN
        start_grat  = 1'b0;
`endif
        unique case (state)
            IDLE: begin
`ifdef ARP_GRATUITOUS_EN
                if (ann_pend) begin
                    state_nx   = GRAT;
                    start_grat = 1'b1;
                end else
`endif
                if (pend_full) begin
                    state_nx    = REPLY;
                    start_reply = 1'b1;
                end
            end
            default: begin
                if (tx_last) begin
                    state_nx = IDLE;
                end
            end
        endcase
    end

    // A capture in the release cycle refills the slot instead of dropping.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            tx_idx      <= '0;
            pend_full   <= 1'b0;
            pend_sha    <= '0;
            pend_spa    <= '0;
            tx_sha      <= '0;
            tx_spa      <= '0;
            reply_cnt_o <= '0;
            drop_cnt_o  <= '0;
        end else begin
            if (tx_fire) begin
                tx_idx <= tx_last ? '0 : tx_idx + 6'd1;
            end
            if (start_reply) begin
                tx_sha <= pend_sha;
                tx_spa <= pend_spa;
            end
            if (need_reply && pend_full && !start_reply) begin
                drop_cnt_o <= drop_cnt_o + CNT_W'(1);
            end else if (need_reply) begin
                pend_full <= 1'b1;
                pend_sha  <= f_sha;
                pend_spa  <= f_spa;
            end else if (start_reply) begin
                pend_full <= 1'b0;
            end
            if (state == REPLY && tx_last) begin
                reply_cnt_o <= reply_cnt_o + CNT_W'(1);
            end
        end
    end

    always_comb begin
        tx_frame = {tx_sha, my_mac_i, 16'h0806,
                    16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0002,
                    my_mac_i, my_ipv4_i, tx_sha, tx_spa};
`ifdef ARP_GRATUITOUS_EN
        if (state == GRAT) begin
            tx_frame = {48'hFFFF_FFFF_FFFF, my_mac_i, 16'h0806,
                        16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0001,
                        my_mac_i, my_ipv4_i, 48'h0, my_ipv4_i};
        end
`endif
        for (int i = 0; i < 42; i++) begin
            tx_b[i] = tx_frame[335 - 8 * i -: 8];
        end
    end

    assign data_tx_o = data_valid_tx_o ? tx_b[tx_idx] : 8'h00;

endmodule

// File: tb/tb_arp_cache_responder.sv
// Self-checking bench for arp_cache_responder: directed tables plus
// randomized frames against a cache/reply reference model.
module tb_arp_cache_responder;
    localparam int DEPTH = 4;
    localparam int CW = 16;
    localparam logic [47:0] MY_MAC = 48'h02_11_22_33_44_55;
    localparam logic [31:0] MY_IP = 32'h0A00_0064;
    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;

    logic clk = 1'b0;
    logic areset = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic rx_valid = 1'b0;
    logic tx_ack = 1'b0;
    logic tx_valid;
    logic [7:0] tx_data;
    logic lk_req = 1'b0;
    logic [31:0] lk_ip = 32'h0;
    logic lk_done;
    logic lk_hit;
    logic [47:0] lk_mac;
    logic [CW-1:0] reply_cnt;
    logic [CW-1:0] drop_cnt;

    always #5 clk = ~clk;

    arp_cache_responder #(.CACHE_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk),
        .areset(areset),
        .data_rx_i(rx_data),
        .data_valid_rx_i(rx_valid),
        .data_ack_tx_i(tx_ack),
        .my_mac_i(MY_MAC),
        .my_ipv4_i(MY_IP),
        .data_valid_tx_o(tx_valid),
        .data_tx_o(tx_data),
        .lookup_req_i(lk_req),
        .lookup_ip_i(lk_ip),
        .lookup_done_o(lk_done),
        .lookup_hit_o(lk_hit),
        .lookup_mac_o(lk_mac),
        .reply_cnt_o(reply_cnt),
        .drop_cnt_o(drop_cnt)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ack_mode = 1;
    logic [7:0] got[$];
    int starts[$];
    int ends[$];
    logic [7:0] fq[$];

    // Sink: mode 0 never acks, 1 always acks, 2 alternates starting low.
    logic pv = 1'b0;
    logic pa = 1'b0;
    logic [7:0] pd = 8'h00;
    int vc = 0;
    always @(negedge clk) begin
        cyc++;
        if (tx_valid) begin
            if (!pv) starts.push_back(cyc);
            if (pv && !pa) begin
                checks++;
                if (tx_data !== pd) begin
                    errors++;
                    $display("FAIL hold: data %h changed from %h unacked",
                             tx_data, pd);
                end
            end
            tx_ack = (ack_mode == 1) || (ack_mode == 2 && vc[0]);
            if (tx_ack) got.push_back(tx_data);
            vc++;
        end else begin
            if (pv) ends.push_back(cyc);
            vc = 0;
            tx_ack = (ack_mode == 1);
        end
        pv = tx_valid;
        pa = tx_ack;
        pd = tx_data;
    end

    task automatic chk(input string nm, input logic [335:0] act,
                       input logic [335:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [335:0] exp_reply(input logic [47:0] sha,
                                               input logic [31:0] spa);
        return {sha, MY_MAC, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04,
                16'h0002, MY_MAC, MY_IP, sha, spa};
    endfunction

    task automatic build(input logic [47:0] dst, input logic [15:0] et,
                         input logic [15:0] ht, input logic [15:0] op,
                         input logic [47:0] sha, input logic [31:0] spa,
                         input logic [31:0] tpa, input int len);
        logic [335:0] v;
        v = {dst, 48'h0A_0B_0C_0D_0E_0F, et, ht, 16'h0800, 8'h06, 8'h04,
             op, sha, spa, 48'h0, tpa};
        fq.delete();
        for (int i = 0; i < len; i++) begin
            fq.push_back(i < 42 ? v[335 - 8 * i -: 8] : 8'h00);
        end
    endtask

    // Returns on the negedge just after edge E; optional lookup in frame-end cycle.
    task automatic send(input bit lk, input logic [31:0] lip);
        foreach (fq[i]) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data = fq[i];
        end
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data = 8'h00;
        if (lk) begin
            lk_req = 1'b1;
            lk_ip = lip;
        end
        @(negedge clk);
        lk_req = 1'b0;
    endtask

    task automatic lookup(input string nm, input logic [31:0] ip,
                          input logic ehit, input logic [47:0] emac);
        @(negedge clk);
        lk_req = 1'b1;
        lk_ip = ip;
        @(negedge clk);
        lk_req = 1'b0;
        chk({nm, " done"}, lk_done, 1'b1);
        chk({nm, " hit"}, lk_hit, ehit);
        if (ehit) chk({nm, " mac"}, lk_mac, emac);
    endtask

    task automatic wait_bytes(input int n, input int budget);
        int k = 0;
        while (got.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (got.size() < n) begin
            checks++;
            errors++;
            $display("FAIL timeout: have %0d bytes, need %0d", got.size(), n);
        end
    endtask

    function automatic logic [335:0] pop_frame();
        logic [335:0] v = '0;
        for (int i = 0; i < 42; i++) begin
            v = {v[327:0], (got.size() > 0) ? got.pop_front() : 8'h00};
        end
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        areset = 1'b0;
        ack_mode = 1;
        #1;
        chk("rst valid", tx_valid, 1'b0);
        chk("rst data", tx_data, 8'h00);
        chk("rst done", lk_done, 1'b0);
        chk("rst hit", lk_hit, 1'b0);
        chk("rst mac", lk_mac, 48'h0);
        chk("rst reply_cnt", reply_cnt, 16'h0);
        chk("rst drop_cnt", drop_cnt, 16'h0);
        @(negedge clk);
        @(negedge clk);
        got.delete();
        starts.delete();
        ends.delete();
        areset = 1'b1;
`ifdef ARP_GRATUITOUS_EN
        wait_bytes(42, 200);
        chk("announce", pop_frame(),
            {BCAST, MY_MAC, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04,
             16'h0001, MY_MAC, MY_IP, 48'h0, MY_IP});
        repeat (3) @(negedge clk);
        chk("announce reply_cnt", reply_cnt, 16'h0);
        starts.delete();
        ends.delete();
`endif
    endtask

    typedef struct {
        logic [47:0] dst;
        logic [15:0] et;
        logic [15:0] ht;
        logic [15:0] op;
        logic [31:0] tpa;
        int len;
        bit rep;
        bit lrn;
    } vec_t;

    vec_t tbl[9];

    logic m_valid[DEPTH];
    logic [31:0] m_ip[DEPTH];
    logic [47:0] m_mac[DEPTH];
    int m_ptr;

    task automatic m_learn(input logic [31:0] ip, input logic [47:0] mac);
        bit found = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (m_valid[i] && m_ip[i] == ip) begin
                m_mac[i] = mac;
                found = 1;
            end
        end
        if (!found) begin
            m_valid[m_ptr] = 1'b1;
            m_ip[m_ptr] = ip;
            m_mac[m_ptr] = mac;
            m_ptr = (m_ptr + 1) % DEPTH;
        end
    endtask

    localparam logic [47:0] SHA1 = 48'h02_00_00_00_00_01;
    localparam logic [31:0] SPA1 = 32'h0A00_0001;

    initial begin
        logic [47:0] sha;
        logic [31:0] spa;
        logic [47:0] dst;
        logic [15:0] et;
        logic [15:0] op;
        logic [31:0] tpa;
        logic [31:0] qip;
        logic exp_hit;
        logic [47:0] exp_mac;
        int len;
        int kind;
        int n_rep;
        bit good;
        bit want;

        tbl[0] = '{BCAST, 16'h0806, 16'h1, 16'h1, MY_IP, 30, 0, 0};
        tbl[1] = '{BCAST, 16'h0800, 16'h1, 16'h1, MY_IP, 42, 0, 0};
        tbl[2] = '{BCAST, 16'h0806, 16'h1, 16'h3, MY_IP, 42, 0, 0};
        tbl[3] = '{48'h02_99_00_00_00_01, 16'h0806, 16'h1, 16'h1, MY_IP,
                   42, 0, 0};
        tbl[4] = '{BCAST, 16'h0806, 16'h2, 16'h1, MY_IP, 42, 0, 0};
        tbl[5] = '{MY_MAC, 16'h0806, 16'h1, 16'h1, MY_IP, 42, 1, 1};
        tbl[6] = '{BCAST, 16'h0806, 16'h1, 16'h1, MY_IP, 60, 1, 1};
        tbl[7] = '{BCAST, 16'h0806, 16'h1, 16'h1, 32'h0A00_00FE, 42, 0, 1};
        tbl[8] = '{BCAST, 16'h0806, 16'h1, 16'h1, MY_IP, 41, 0, 0};

        do_reset();

        // Basic reply: latency, content, completion count.
        build(BCAST, 16'h0806, 16'h1, 16'h1, SHA1, SPA1, MY_IP, 42);
        send(0, 32'h0);
        chk("lat E valid", tx_valid, 1'b0);
        @(negedge clk);
        chk("lat E+1 valid", tx_valid, 1'b1);
        chk("lat first byte", tx_data, 8'h02);
        wait_bytes(42, 100);
        chk("reply1", pop_frame(), exp_reply(SHA1, SPA1));
        repeat (4) @(negedge clk);
        chk("reply1 cnt", reply_cnt, 16'd1);
        chk("reply1 span", (starts.size() > 0 && ends.size() > 0)
                           ? ends[0] - starts[0] : -1, 42);

        // Alternating ack: same bytes, 84 valid cycles.
        starts.delete();
        ends.delete();
        ack_mode = 2;
        send(0, 32'h0);
        wait_bytes(42, 200);
        repeat (4) @(negedge clk);
        chk("toggle bytes", pop_frame(), exp_reply(SHA1, SPA1));
        chk("toggle span", (starts.size() > 0 && ends.size() > 0)
                           ? ends[0] - starts[0] : -1, 84);
        chk("toggle cnt", reply_cnt, 16'd2);

        // Three requests while the sink stalls.
        do_reset();
        ack_mode = 0;
        for (int k = 0; k < 3; k++) begin
            build(BCAST, 16'h0806, 16'h1, 16'h1, 48'h02_00_00_00_00_0A + k,
                  32'h0A00_0010 + k, MY_IP, 42);
            send(0, 32'h0);
        end
        chk("b2b drop", drop_cnt, 16'd1);
        chk("b2b stalled cnt", reply_cnt, 16'd0);
        ack_mode = 1;
        wait_bytes(84, 300);
        repeat (4) @(negedge clk);
        chk("b2b first", pop_frame(),
            exp_reply(48'h02_00_00_00_00_0A, 32'h0A00_0010));
        chk("b2b second", pop_frame(),
            exp_reply(48'h02_00_00_00_00_0B, 32'h0A00_0011));
        chk("b2b cnt", reply_cnt, 16'd2);
        chk("b2b gap", (starts.size() > 1 && ends.size() > 0)
                       ? starts[1] - ends[0] : -1, 1);
        chk("b2b extra", got.size(), 0);

        // Cache replacement, in-place update, lookup during write.
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            build(BCAST, 16'h0806, 16'h1, 16'h2, 48'h02_00_00_00_10_00 + k,
                  32'h0A00_0000 + k, 32'h0A00_00FE, 42);
            send(0, 32'h0);
        end
        lookup("lk .1", 32'h0A00_0001, 1'b0, 48'h0);
        lookup("lk .5", 32'h0A00_0005, 1'b1, 48'h02_00_00_00_10_05);
        lookup("lk .2", 32'h0A00_0002, 1'b1, 48'h02_00_00_00_10_02);
        build(BCAST, 16'h0806, 16'h1, 16'h2, 48'h02_00_00_00_99_99,
              32'h0A00_0003, 32'h0A00_00FE, 42);
        send(0, 32'h0);
        build(BCAST, 16'h0806, 16'h1, 16'h2, 48'h02_00_00_00_10_06,
              32'h0A00_0006, 32'h0A00_00FE, 42);
        send(1, 32'h0A00_0006);
        chk("lk same-cycle done", lk_done, 1'b1);
        chk("lk same-cycle hit", lk_hit, 1'b0);
        lookup("lk .3 new", 32'h0A00_0003, 1'b1, 48'h02_00_00_00_99_99);
        lookup("lk .2 evict", 32'h0A00_0002, 1'b0, 48'h0);
        lookup("lk .4", 32'h0A00_0004, 1'b1, 48'h02_00_00_00_10_04);
        lookup("lk .6", 32'h0A00_0006, 1'b1, 48'h02_00_00_00_10_06);
        chk("learn no reply", reply_cnt, 16'd0);

        // Table of accepted and hostile frames.
        for (int t = 0; t < 9; t++) begin
            do_reset();
            build(tbl[t].dst, tbl[t].et, tbl[t].ht, tbl[t].op,
                  48'h02_AA_BB_CC_DD_EE, 32'h0A00_0207, tbl[t].tpa,
                  tbl[t].len);
            send(0, 32'h0);
            repeat (60) @(negedge clk);
            chk($sformatf("tbl%0d reply_cnt", t), reply_cnt,
                tbl[t].rep ? 16'd1 : 16'd0);
            chk($sformatf("tbl%0d bytes", t), got.size(),
                tbl[t].rep ? 42 : 0);
            lookup($sformatf("tbl%0d learn", t), 32'h0A00_0207,
                   tbl[t].lrn, 48'h02_AA_BB_CC_DD_EE);
        end

        // Reset in the middle of a reply.
        do_reset();
        build(BCAST, 16'h0806, 16'h1, 16'h1, SHA1, SPA1, MY_IP, 42);
        send(0, 32'h0);
        wait_bytes(20, 100);
        #2;
        areset = 1'b0;
        #1;
        chk("abort valid", tx_valid, 1'b0);
        do_reset();
        lookup("abort lookup", SPA1, 1'b0, 48'h0);

        // Randomized frames against the reference model.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 1'b0;
            m_ip[i] = '0;
            m_mac[i] = '0;
        end
        m_ptr = 0;
        n_rep = 0;
        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 9);
            sha = {8'h02, 8'($urandom), 32'($urandom)};
            spa = ($urandom_range(0, 9) == 0) ? 32'h0
                  : 32'h0A00_0100 + 32'($urandom_range(1, 7));
            dst = ($urandom_range(0, 1) == 1) ? BCAST : MY_MAC;
            op = 16'($urandom_range(1, 2));
            tpa = ($urandom_range(0, 2) != 0) ? MY_IP : 32'h0A00_00FE;
            len = $urandom_range(42, 50);
            et = 16'h0806;
            good = 1;
            if (kind == 7) begin
                good = 0;
                len = $urandom_range(1, 41);
            end else if (kind == 8) begin
                good = 0;
                et = 16'h86DD;
            end else if (kind == 9) begin
                good = 0;
                op = 16'h0003;
            end
            want = good && op == 16'h1 && tpa == MY_IP;
            if (good && spa != 32'h0) m_learn(spa, sha);
            if (want) n_rep++;
            ack_mode = $urandom_range(1, 2);
            build(dst, et, 16'h1, op, sha, spa, tpa, len);
            send(0, 32'h0);
            repeat (95) @(negedge clk);
            if (want) begin
                wait_bytes(42, 20);
                chk($sformatf("rand%0d reply", it), pop_frame(),
                    exp_reply(sha, spa));
            end
            chk($sformatf("rand%0d leftover", it), got.size(), 0);
            qip = 32'h0A00_0100 + 32'($urandom_range(1, 7));
            exp_hit = 1'b0;
            exp_mac = 48'h0;
            for (int j = 0; j < DEPTH; j++) begin
                if (m_valid[j] && m_ip[j] == qip) begin
                    exp_hit = 1'b1;
                    exp_mac = m_mac[j];
                end
            end
            lookup($sformatf("rand%0d lookup", it), qip, exp_hit, exp_mac);
        end
        chk("rand reply_cnt", reply_cnt, 16'(n_rep));
        chk("rand drop_cnt", drop_cnt, 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
